// File: rtl/vga_pkg.sv
// Shared VGA timing constants, fetch FSM states and RGB332 expansion.
// Used by the pixel fetch stage and its helpers.
package vga_pkg;

  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic {
    WAIT_FRAME,
    ACTIVE
  } fetch_state_t;

  // Replicate the top bits so full-scale codes reach 8'hFF
  function automatic logic [23:0] rgb332_to_rgb888(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6],
            d[4:2], d[4:2], d[4:3],
            {4{d[1:0]}}};
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipeline with a per-bit reset value,
// used to keep sync and blanking aligned with fetched colour.
module vga_delay_line #(
  parameter int             W       = 1,
  parameter int             DEPTH   = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= RST_VAL;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer fetch ahead of the VGA sync stage: scaled addressing,
// RGB332 expansion and sync re-timing with a fixed 2-cycle latency.
module vga_pixel_fetch #(
  parameter int          H_ACTIVE    = 640,
  parameter int          V_ACTIVE    = 480,
  parameter int          IMG_W       = 160,
  parameter int          IMG_H       = 120,
  parameter int          SCALE_SHIFT = 2,
  parameter logic [7:0]  BORDER_RGB  = 8'h00
) (
  input  logic        CLK25MHZ,
  input  logic        RST_N,
  input  logic [9:0]  counter_x,
  input  logic [9:0]  counter_y,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        enable,
  input  logic [7:0]  mem_rdata,
  output logic [14:0] mem_addr,
  output logic        mem_rd_en,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        frame_start
);
  import vga_pkg::*;

  localparam logic [9:0]  SUB_M    = 10'((1 << SCALE_SHIFT) - 1);
  localparam logic [9:0]  WIN_W    = 10'(IMG_W << SCALE_SHIFT);
  localparam logic [9:0]  WIN_H    = 10'(IMG_H << SCALE_SHIFT);
  localparam logic [9:0]  WIN_YL   = WIN_H - 10'd1;
  localparam logic [9:0]  X_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [14:0] ROW_STEP = 15'(IMG_W);

  fetch_state_t state_q, state_d;
  logic [9:0]   col_q, col_d, col_cur;
  logic [14:0]  row_q, row_d, row_cur;
  logic [14:0]  addr_q, addr_d;
  logic         rd_q, rd_d;
  logic         fs_q, vis1_q, vis2_q, rd2_q;
  logic         fs, act, in_win, run, line_end;
  logic [2:0]   sync_q;
  logic [23:0]  rgb;

  assign fs       = (counter_x == '0) && (counter_y == '0);
  assign act      = (counter_x <= X_LAST) && (counter_y <= Y_LAST);
  assign in_win   = (counter_x < WIN_W) && (counter_y < WIN_H);
  assign line_end = (counter_x == X_LAST);

  // enable only matters at the frame boundary
  always_comb begin
    state_d = state_q;
    run     = (state_q == ACTIVE);
    if (fs) begin
      state_d = enable ? ACTIVE : WAIT_FRAME;
      run     = enable;
    end else if (line_end && counter_y == Y_LAST && !enable) begin
      state_d = WAIT_FRAME;
    end
  end

  always_comb begin
    col_cur = (counter_x == '0) ? '0 : col_q;
    row_cur = fs ? '0 : row_q;
    col_d   = col_cur + {9'd0, (counter_x & SUB_M) == SUB_M};
    row_d   = row_cur;
    if (line_end) begin
      if (counter_y == Y_LAST) begin
        row_d = '0;
      end else if ((counter_y & SUB_M) == SUB_M
                   && counter_y < WIN_YL) begin
        row_d = row_cur + ROW_STEP;
      end
    end
    rd_d   = run && act && in_win;
    // hold the last legal address between reads
    addr_d = rd_d ? row_cur + 15'(col_cur) : addr_q;
  end

  always_ff @(posedge CLK25MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= WAIT_FRAME;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      fs_q    <= 1'b0;
      vis1_q  <= 1'b0;
      vis2_q  <= 1'b0;
      rd2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      fs_q    <= fs;
      vis1_q  <= run && act;
      vis2_q  <= vis1_q;
      rd2_q   <= rd_q;
    end
  end

  vga_delay_line #(
    .W       (3),
    .DEPTH   (2),
    .RST_VAL (3'b110)
  ) u_sync_dly (
    .clk_i  (CLK25MHZ),
    .rst_ni (RST_N),
    .d_i    ({hs_in, vs_in, act}),
    .q_o    (sync_q)
  );

  // memory data arrives in the same cycle as the delayed syncs
  always_comb begin
    rgb = '0;
    if (vis2_q) begin
      rgb = rd2_q ? rgb332_to_rgb888(mem_rdata)
                  : rgb332_to_rgb888(BORDER_RGB);
    end
  end

  assign {VGA_R, VGA_G, VGA_B}       = rgb;
  assign {VGA_HS, VGA_VS, VGA_BLANK_N} = sync_q;
  assign mem_addr    = addr_q;
  assign mem_rd_en   = rd_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: default 160x120 instance plus a
// 100x100 instance with a blue border, sharing one counter stream.
module tb_vga_pixel_fetch;

  logic        clk = 1'b0;
  logic        RST_N;
  logic [9:0]  counter_x, counter_y;
  logic        hs_in, vs_in, enable;

  logic [7:0]  rdata_a = '0, rdata_b = '0;
  logic [14:0] addr_a, addr_b;
  logic        rd_a, rd_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hs_a, vs_a, bl_a, fs_a;
  logic        hs_b, vs_b, bl_b, fs_b;

  int npass = 0;
  int ntot  = 0;
  logic seen;

  always #20 clk = ~clk;

  vga_pixel_fetch u_a (
    .CLK25MHZ(clk), .RST_N(RST_N),
    .counter_x(counter_x), .counter_y(counter_y),
    .hs_in(hs_in), .vs_in(vs_in), .enable(enable),
    .mem_rdata(rdata_a), .mem_addr(addr_a), .mem_rd_en(rd_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bl_a),
    .frame_start(fs_a)
  );

  vga_pixel_fetch #(
    .IMG_W(100), .IMG_H(100), .BORDER_RGB(8'h03)
  ) u_b (
    .CLK25MHZ(clk), .RST_N(RST_N),
    .counter_x(counter_x), .counter_y(counter_y),
    .hs_in(hs_in), .vs_in(vs_in), .enable(enable),
    .mem_rdata(rdata_b), .mem_addr(addr_b), .mem_rd_en(rd_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bl_b),
    .frame_start(fs_b)
  );

  function automatic logic [7:0] memf(input logic [14:0] a);
    if (a == 15'd0) return 8'hE0;
    if (a == 15'd1) return 8'h1C;
    return a[7:0];
  endfunction

  always @(posedge clk) begin
    if (rd_a) rdata_a <= memf(addr_a);
    if (rd_b) rdata_b <= memf(addr_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic px(input int x, input int y);
    counter_x = 10'(x);
    counter_y = 10'(y);
    hs_in     = !(x >= 656 && x < 752);
    vs_in     = !(y >= 490 && y < 492);
    @(posedge clk);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; enable = 1'b1;
    counter_x = 10'd100; counter_y = 10'd5;
    hs_in = 1'b1; vs_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", {r_a, g_a, b_a}, 24'h0);
    chk("rst_hs", hs_a, 1);
    chk("rst_vs", vs_a, 1);
    chk("rst_blank", bl_a, 0);
    chk("rst_rd", rd_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_fs", fs_a, 0);
    RST_N = 1'b1;

    seen = 1'b0;
    for (int x = 100; x < 110; x++) begin
      px(x, 5);
      seen |= rd_a;
    end
    chk("no_rd_before_frame", seen, 0);

    // frame 1
    px(0, 0);
    chk("f1_fs", fs_a, 1);
    chk("f1_rd0", rd_a, 1);
    chk("f1_addr0", addr_a, 0);
    px(1, 0);
    chk("f1_rgb00", {r_a, g_a, b_a}, 24'hFF0000);
    chk("f1_blank00", bl_a, 1);
    chk("f1_hs00", hs_a, 1);
    chk("f1_fs_pulse", fs_a, 0);
    px(2, 0); px(3, 0); px(4, 0);
    chk("addr_x4", addr_a, 1);
    px(5, 0);
    chk("rgb_x4", {r_a, g_a, b_a}, 24'h00FF00);
    for (int x = 6; x < 800; x++) begin
      px(x, 0);
      if (x == 640) chk("blank_rd", rd_a, 0);
      if (x == 641) chk("blank_rgb", {r_a, g_a, b_a}, 24'h0);
      if (x == 641) chk("blank_n", bl_a, 0);
      if (x == 657) chk("hs_delay", hs_a, 0);
    end
    px(0, 1);
    chk("col_restart", addr_a, 0);
    px(639, 1);
    for (int y = 2; y < 4; y++) begin
      px(0, y); px(639, y);
    end
    px(0, 4);
    chk("addr_y4", addr_a, 160);
    px(639, 4);
    for (int y = 5; y < 480; y++) begin
      if (y == 399 || y == 479) begin
        for (int x = 0; x < 640; x++) begin
          px(x, y);
          if (y == 399 && x == 399) chk("b_addr_max", addr_b, 9999);
          if (y == 399 && x == 400) chk("b_rd_edge", rd_b, 0);
          if (y == 399 && x == 639) chk("b_addr_hold", addr_b, 9999);
        end
      end else begin
        px(0, y);
        if (y == 10) begin
          px(500, 10);
          chk("b_border_rd", rd_b, 0);
          px(501, 10);
          chk("b_border_rgb", {r_b, g_b, b_b}, 24'h0000FF);
        end
        px(639, y);
      end
    end
    chk("a_addr_last", addr_a, 19199);
    chk("a_rd_last", rd_a, 1);
    chk("b_addr_last", addr_b, 9999);
    px(640, 479);
    chk("rgb_last", {r_a, g_a, b_a}, 24'hFFFFFF);
    chk("blank_last", bl_a, 1);
    px(0, 490); px(1, 490);
    chk("vs_delay", vs_a, 0);
    chk("vblank_n", bl_a, 0);

    // frame 2: enable drops mid-frame
    px(0, 0);
    chk("f2_rd", rd_a, 1);
    for (int y = 1; y < 480; y++) begin
      px(0, y);
      if (y == 200) begin
        px(320, 200);
        enable = 1'b0;
      end
      px(639, y);
      if (y == 300) chk("f2_rd_after_drop", rd_a, 1);
    end
    chk("f2_rd_end", rd_a, 1);

    // frame 3: disabled
    seen = 1'b0;
    px(0, 0);
    chk("f3_fs", fs_a, 1);
    seen |= rd_a;
    px(1, 0);
    chk("f3_rgb", {r_a, g_a, b_a}, 24'h0);
    chk("f3_blank_n", bl_a, 1);
    for (int x = 2; x < 20; x++) begin
      px(x, 0);
      seen |= rd_a;
    end
    for (int y = 1; y < 480; y++) begin
      px(0, y); seen |= rd_a;
      px(639, y); seen |= rd_a;
    end
    chk("f3_no_rd", seen, 0);

    // frame 4: re-enable, then reset mid-line
    enable = 1'b1;
    px(0, 0);
    chk("f4_rd", rd_a, 1);
    px(700, 2); px(701, 2);
    chk("pre_rst_hs", hs_a, 0);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_hs", hs_a, 1);
    chk("mid_rst_vs", vs_a, 1);
    chk("mid_rst_rd", rd_a, 0);
    chk("mid_rst_addr", addr_a, 0);
    chk("mid_rst_blank", bl_a, 0);
    #5 RST_N = 1'b1;
    seen = 1'b0;
    px(702, 2);
    px(0, 3); seen |= rd_a;
    px(10, 3); seen |= rd_a;
    chk("post_rst_no_rd", seen, 0);
    px(0, 0);
    chk("post_rst_rd", rd_a, 1);
    chk("post_rst_addr", addr_a, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
